// File: rtl/video_frame_encoder.sv
// Composite raster generator that carries payload bytes as amplitude symbols
// on each active line, pulled from a valid/ready byte stream.
module video_frame_encoder #(
    parameter int H_TOTAL          = 858,
    parameter int H_SYNC           = 64,
    parameter int H_ACTIVE_START   = 122,
    parameter int V_TOTAL          = 525,
    parameter int V_SYNC           = 6,
    parameter int V_ACTIVE_START   = 20,
    parameter int V_ACTIVE         = 480,
    parameter int BITS_PER_SYMBOL  = 2,
    parameter int SYMBOL_CYCLES    = 4,
    parameter int PREAMBLE_SYMBOLS = 8,
    parameter int PAYLOAD_BYTES    = 20,
    parameter int SYNC_LEVEL       = 0,
    parameter int BLANK_LEVEL      = 60,
    parameter int BLACK_LEVEL      = 70,
    parameter int WHITE_LEVEL      = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  video,
    output logic        sync_n,
    output logic        frame_start,
    output logic [15:0] underrun_count
);

    localparam int SPB   = 8 / BITS_PER_SYMBOL;
    localparam int NS    = PREAMBLE_SYMBOLS + 1 + PAYLOAD_BYTES * SPB;
    localparam int F_CLK = H_ACTIVE_START + PREAMBLE_SYMBOLS * SYMBOL_CYCLES;
    localparam int MAXS  = (1 << BITS_PER_SYMBOL) - 1;
    localparam int HW    = $clog2(H_TOTAL + 1);
    localparam int VW    = $clog2(V_TOTAL + 1);
    localparam int IW    = $clog2(NS + 1);
    localparam int PW    = $clog2(SYMBOL_CYCLES + 1);
    localparam logic [7:0] SYM_MAX = 8'(MAXS);

    if (BITS_PER_SYMBOL != 1 && BITS_PER_SYMBOL != 2 &&
        BITS_PER_SYMBOL != 4 && BITS_PER_SYMBOL != 8) begin : g_bad_bps
        $error("BITS_PER_SYMBOL must be 1, 2, 4 or 8");
    end
    if (PREAMBLE_SYMBOLS % 2 != 0) begin : g_bad_pre
        $error("PREAMBLE_SYMBOLS must be even");
    end
    if (H_ACTIVE_START + NS * SYMBOL_CYCLES > H_TOTAL) begin : g_bad_h
        $error("symbol window does not fit in the line");
    end
    if (V_ACTIVE_START + V_ACTIVE > V_TOTAL) begin : g_bad_v
        $error("active lines do not fit in the frame");
    end

    function automatic logic [7:0] level(input logic [7:0] s);
        int lv;
        lv = BLACK_LEVEL + (int'(s) * (WHITE_LEVEL - BLACK_LEVEL)) / MAXS;
        return 8'(lv);
    endfunction

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          in_win;
    logic [IW-1:0] sym_idx;
    logic [PW-1:0] sym_phase;
    logic          data_line;
    logic [7:0]    shreg;

    int         hi, vi, si;
    logic       active, win, sym_end, byte_edge, fetch, shift;
    logic [7:0] sym, video_d;
    logic       sync_d, frame_d;

    always_comb begin
        hi        = int'(h_cnt);
        vi        = int'(v_cnt);
        si        = int'(sym_idx);
        active    = vi >= V_ACTIVE_START &&
                    vi < V_ACTIVE_START + V_ACTIVE;
        win       = in_win && active;
        sym_end   = int'(sym_phase) == SYMBOL_CYCLES - 1;
        // last clock of the flag or of a byte's final symbol
        byte_edge = si >= PREAMBLE_SYMBOLS && si < NS - 1 &&
                    (si - PREAMBLE_SYMBOLS) % SPB == 0;
        fetch     = win && sym_end && byte_edge;
        shift     = win && sym_end && si > PREAMBLE_SYMBOLS;
        in_ready  = data_line && fetch;
        frame_d   = hi == 0 && vi == 0;

        sym = 8'd0;
        if (si < PREAMBLE_SYMBOLS)
            sym = (si % 2 == 0) ? SYM_MAX : 8'd0;
        else if (si == PREAMBLE_SYMBOLS)
            sym = data_line ? SYM_MAX : 8'd0;
        else if (data_line)
            sym = 8'(shreg[7 -: BITS_PER_SYMBOL]);

        sync_d  = 1'b1;
        video_d = 8'(BLANK_LEVEL);
        if (vi < V_SYNC) begin
            sync_d = hi >= H_TOTAL - H_SYNC;
        end else if (hi < H_SYNC) begin
            sync_d  = 1'b0;
            video_d = 8'(SYNC_LEVEL);
        end else if (win) begin
            video_d = level(sym);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (hi == H_TOTAL - 1) begin
            h_cnt <= '0;
            v_cnt <= (vi == V_TOTAL - 1) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_win    <= 1'b0;
            sym_idx   <= '0;
            sym_phase <= '0;
        end else if (hi == H_ACTIVE_START - 1) begin
            in_win    <= 1'b1;
            sym_idx   <= '0;
            sym_phase <= '0;
        end else if (in_win) begin
            if (sym_end) begin
                sym_phase <= '0;
                if (si == NS - 1)
                    in_win <= 1'b0;
                else
                    sym_idx <= sym_idx + IW'(1);
            end else begin
                sym_phase <= sym_phase + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            data_line <= 1'b0;
        else if (hi == F_CLK - 1)
            data_line <= active && enable && in_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            shreg <= '0;
        else if (in_ready)
            shreg <= in_valid ? in_data : 8'h00;
        else if (shift)
            shreg <= shreg << BITS_PER_SYMBOL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            underrun_count <= '0;
        else if (in_ready && !in_valid && underrun_count != 16'hFFFF)
            underrun_count <= underrun_count + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            video       <= 8'(BLANK_LEVEL);
            sync_n      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            video       <= video_d;
            sync_n      <= sync_d;
            frame_start <= frame_d;
        end
    end

endmodule

// File: tb/tb_video_frame_encoder.sv
// Directed bench for video_frame_encoder: raster, symbol lines, byte fetch,
// 8-bit symbols, underrun saturation and mid-line reset.
module tb_video_frame_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_s;

    logic        enable, in_valid, in_ready, sync_n, frame_start;
    logic [7:0]  in_data, video;
    logic [15:0] underrun_count;

    logic        en8, valid8, rdy8, sync8, fs8;
    logic [7:0]  data8, video8;
    logic [15:0] ur8;

    logic        en_s, valid_s, rdy_s, sync_s, fs_s;
    logic [7:0]  data_s, video_s;
    logic [15:0] ur_s;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ur_exp = 0;
    int lows;

    video_frame_encoder #(
        .H_TOTAL(300), .V_TOTAL(30), .V_SYNC(3),
        .V_ACTIVE_START(5), .V_ACTIVE(20), .PAYLOAD_BYTES(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .video(video), .sync_n(sync_n), .frame_start(frame_start),
        .underrun_count(underrun_count)
    );

    video_frame_encoder #(
        .H_TOTAL(300), .V_TOTAL(30), .V_SYNC(3),
        .V_ACTIVE_START(5), .V_ACTIVE(20), .PAYLOAD_BYTES(4),
        .BITS_PER_SYMBOL(8), .SYMBOL_CYCLES(1)
    ) dut8 (
        .clk(clk), .rst(rst), .enable(en8),
        .in_data(data8), .in_valid(valid8), .in_ready(rdy8),
        .video(video8), .sync_n(sync8), .frame_start(fs8),
        .underrun_count(ur8)
    );

    video_frame_encoder #(
        .H_TOTAL(2000), .H_SYNC(4), .H_ACTIVE_START(8),
        .V_TOTAL(2), .V_SYNC(0), .V_ACTIVE_START(0), .V_ACTIVE(2),
        .BITS_PER_SYMBOL(8), .SYMBOL_CYCLES(1),
        .PREAMBLE_SYMBOLS(2), .PAYLOAD_BYTES(1980)
    ) dut_s (
        .clk(clk), .rst(rst_s), .enable(en_s),
        .in_data(data_s), .in_valid(valid_s), .in_ready(rdy_s),
        .video(video_s), .sync_n(sync_s), .frame_start(fs_s),
        .underrun_count(ur_s)
    );

    always @(posedge clk)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // {sync_n, video} for the main instance at (line, clock)
    function automatic logic [8:0] model(input int v, input int h,
                                         input logic dl,
                                         input logic [31:0] b);
        logic [7:0] lv [4];
        int k, p, s;
        lv = '{8'd70, 8'd113, 8'd156, 8'd200};
        if (v < 3) return {h >= 236, 8'd60};
        if (h < 64) return {1'b0, 8'd0};
        if (v >= 5 && v < 25 && h >= 122 && h < 222) begin
            k = (h - 122) / 4;
            if (k < 8) return {1'b1, (k % 2 == 0) ? 8'd200 : 8'd70};
            if (k == 8) return {1'b1, dl ? 8'd200 : 8'd70};
            p = k - 9;
            s = int'((b >> (30 - 8 * (p / 4) - 2 * (p % 4))) & 32'd3);
            return {1'b1, lv[s]};
        end
        return {1'b1, 8'd60};
    endfunction

    task automatic run_line(input int line, input logic en,
                            input logic dv, input logic [31:0] bytes,
                            input logic [3:0] vm, input int drop_at,
                            output int nlow);
        logic [7:0]  vid [300];
        logic        syn [300];
        logic        rdy [300];
        logic        dl, er;
        logic [31:0] eb;
        logic [8:0]  m;
        dl = en && dv && line >= 5 && line < 25;
        eb = '0;
        for (int j = 0; j < 4; j++)
            if (dl && vm[j]) eb[31-8*j -: 8] = bytes[31-8*j -: 8];
        goto(line * 300);
        enable   = en;
        in_valid = dv;
        for (int i = 0; i <= 300; i++) begin
            goto(line * 300 + i);
            if (i == drop_at) enable = 1'b0;
            for (int j = 0; j < 4; j++)
                if (i == 157 + 16 * j) begin
                    in_data  = bytes[31-8*j -: 8];
                    in_valid = vm[j];
                end
            if (i < 300) rdy[i] = in_ready;
            if (i > 0) begin
                vid[i-1] = video;
                syn[i-1] = sync_n;
            end
        end
        nlow = 0;
        for (int h = 0; h < 300; h++) begin
            m  = model(line, h, dl, eb);
            er = dl && (h == 157 || h == 173 || h == 189 || h == 205);
            chk($sformatf("video l%0d h%0d", line, h), 32'(vid[h]),
                32'(m[7:0]));
            chk($sformatf("sync_n l%0d h%0d", line, h), 32'(syn[h]),
                32'(m[8]));
            chk($sformatf("in_ready l%0d h%0d", line, h), 32'(rdy[h]),
                32'(er));
            if (!syn[h]) nlow++;
        end
        if (dl)
            for (int j = 0; j < 4; j++)
                if (!vm[j]) ur_exp++;
        chk($sformatf("underrun l%0d", line), 32'(underrun_count),
            32'(ur_exp));
    endtask

    initial begin
        enable = 0; in_valid = 0; in_data = 0;
        en8 = 1; valid8 = 1; data8 = 8'h80;
        en_s = 1; valid_s = 0; data_s = 8'hAA;
        rst = 1; rst_s = 1;
        #2 rst = 0; rst_s = 0;
        repeat (3) @(negedge clk);
        chk("rst video", 32'(video), 32'd60);
        chk("rst sync_n", 32'(sync_n), 32'd1);
        chk("rst frame_start", 32'(frame_start), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst underrun", 32'(underrun_count), 32'd0);
        chk("rst video8", 32'(video8), 32'd60);
        rst = 1; rst_s = 1;
        fork
            begin
                goto(1);
                chk("first frame_start", 32'(frame_start), 32'd1);
                chk("l0h0 sync_n", 32'(sync_n), 32'd0);
                chk("l0h0 video", 32'(video), 32'd60);
                goto(2);
                chk("frame_start width", 32'(frame_start), 32'd0);
                run_line(2, 0, 0, 32'h0, 4'h0, -1, lows);
                chk("vsync low clocks", 32'(lows), 32'd236);
                run_line(5, 0, 1, 32'h12345678, 4'hF, -1, lows);
                chk("hsync low clocks", 32'(lows), 32'd64);
                run_line(6, 1, 1, 32'h1BE4A53C, 4'hF, -1, lows);
                run_line(7, 1, 1, 32'h11223344, 4'b1011, -1, lows);
                run_line(8, 1, 1, 32'hFF00FF00, 4'hF, 160, lows);
                run_line(9, 1, 0, 32'hAAAAAAAA, 4'hF, -1, lows);
                enable = 0; in_valid = 0;
                goto(9000);
                chk("frame end no pulse", 32'(frame_start), 32'd0);
                goto(9001);
                chk("frame period", 32'(frame_start), 32'd1);
                enable = 1; in_valid = 1; in_data = 8'hFF;
                goto(10973);
                chk("pre-rst in_ready", 32'(in_ready), 32'd1);
                chk("pre-rst video", 32'(video), 32'd200);
                chk("pre-rst underrun", 32'(underrun_count), 32'd1);
                #1 rst = 0;
                #1;
                chk("mid rst video", 32'(video), 32'd60);
                chk("mid rst sync_n", 32'(sync_n), 32'd1);
                chk("mid rst in_ready", 32'(in_ready), 32'd0);
                chk("mid rst frame_start", 32'(frame_start), 32'd0);
                chk("mid rst underrun", 32'(underrun_count), 32'd0);
                @(negedge clk);
                rst = 1;
                goto(1);
                chk("restart frame_start", 32'(frame_start), 32'd1);
                chk("restart sync_n", 32'(sync_n), 32'd0);
            end
            begin
                goto(1623);
                chk("b8 preamble0", 32'(video8), 32'd200);
                goto(1624);
                chk("b8 preamble1", 32'(video8), 32'd70);
                goto(1630);
                chk("b8 in_ready first", 32'(rdy8), 32'd1);
                goto(1631);
                chk("b8 flag", 32'(video8), 32'd200);
                goto(1632);
                chk("b8 byte 0x80", 32'(video8), 32'd135);
                goto(1634);
                chk("b8 in_ready end", 32'(rdy8), 32'd0);
                goto(1635);
                chk("b8 last byte", 32'(video8), 32'd135);
                goto(1636);
                chk("b8 after window", 32'(video8), 32'd60);
                chk("b8 underrun", 32'(ur8), 32'd0);
            end
            begin
                for (int c = 0; c <= 68000; c++) begin
                    valid_s = (c % 2000 == 9);
                    if (c == 9) chk("sat ready pre", 32'(rdy_s), 32'd0);
                    if (c == 10) chk("sat ready", 32'(rdy_s), 32'd1);
                    if (c == 2000) chk("sat line0", 32'(ur_s), 32'd1980);
                    if (c == 66000) chk("sat 33 lines", 32'(ur_s), 32'd65340);
                    if (c == 66204) chk("sat FFFE", 32'(ur_s), 32'hFFFE);
                    if (c == 66205) chk("sat FFFF", 32'(ur_s), 32'hFFFF);
                    if (c == 68000) chk("sat hold", 32'(ur_s), 32'hFFFF);
                    @(negedge clk);
                end
            end
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
